cvxif_mac_coprocessor: RTL and testbench

- CV-X-IF coprocessor that sits downstream of the core's X-interface.
- Decodes custom-3 instructions (ADD, SUB, MUL, MAC) on the issue interface and buffers accepted instructions in an in-order queue until the core commits or kills them.
- Executes committed instructions on a single multi-cycle ALU that holds an internal MAC accumulator, then returns results on a valid/ready result channel.

---
 rtl/cvxif_mac_coprocessor.sv | 225 ++++++++++++++++++++++
 tb/tb_cvxif_mac_coprocessor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_mac_coprocessor.sv
// cvxif_mac_coprocessor: custom-3 ADD/SUB/MUL/MAC coprocessor behind the X-interface.
// Accepted instructions wait in an in-order queue until commit or kill.
// Committed instructions at the head run one at a time on a multi-cycle ALU.
// The MAC accumulator is only touched by committed work.
//
// Handshake semantics:
//   issue:  a transfer happens on a cycle with issue_valid_i & issue_ready_o.
//           issue_ready_o does not depend on issue_valid_i.
//           accept/writeback report the decode result for that transfer.
//   result: a transfer happens on a cycle with result_valid_o & result_ready_i.
//           While valid is high, id/rd/data hold steady until ready is seen.
module cvxif_mac_coprocessor #(
  parameter int XLen       = 64,
  parameter int IdWidth    = 3,
  parameter int Depth      = 4,
  parameter int MulLatency = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLen-1:0]    issue_rs1_i,
  input  logic [XLen-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o,
  output logic [XLen-1:0]    result_data_o,
  output logic [1:0]         dbg_state_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam int LatW = $clog2(MulLatency + 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_MAC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // queue storage
  logic [IdWidth-1:0] r_q_id     [Depth];
  logic [1:0]         r_q_op     [Depth];
  logic [XLen-1:0]    r_q_rs1    [Depth];
  logic [XLen-1:0]    r_q_rs2    [Depth];
  logic [4:0]         r_q_rd     [Depth];
  logic               r_q_valid  [Depth];
  logic               r_q_commit [Depth];
  logic               r_q_kill   [Depth];
  logic [PtrW-1:0]    r_head, r_tail;
  logic [CntW-1:0]    r_count;

  // execution state
  state_e             r_state, w_state_nxt;
  logic [1:0]         r_op;
  logic [XLen-1:0]    r_a, r_b, r_acc, r_res_data;
  logic [IdWidth-1:0] r_res_id;
  logic [4:0]         r_res_rd;
  logic [LatW-1:0]    r_cnt;

  logic               w_dec_ok, w_full, w_enq, w_head_valid;
  logic               w_pop, w_start, w_finish;
  logic [1:0]         w_dec_op;
  logic [XLen-1:0]    w_prod, w_alu;
  logic               w_unused_rs_fields;

  // The rs1/rs2 register fields are resolved by the core; only values arrive here.
  assign w_unused_rs_fields = ^issue_instr_i[24:15];

  assign w_dec_ok = (issue_instr_i[6:0] == 7'b1111011) &&
                    (issue_instr_i[31:25] == 7'd0) && !issue_instr_i[14];
  assign w_dec_op = issue_instr_i[13:12];

  // Ready uses the registered occupancy, so enqueue never races a pop when full.
  assign w_full            = (r_count == CntW'(Depth));
  assign issue_ready_o     = !w_full && (issue_rs_valid_i == 2'b11);
  assign issue_accept_o    = issue_valid_i && w_dec_ok;
  assign issue_writeback_o = issue_valid_i && w_dec_ok;
  assign w_enq             = issue_valid_i && issue_ready_o && w_dec_ok;
  assign w_head_valid      = (r_count != '0);

  // Queue: enqueue at tail, commit/kill by id match, pop at head.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_q_valid[i]  <= 1'b0;
        r_q_commit[i] <= 1'b0;
        r_q_kill[i]   <= 1'b0;
      end
    end else begin
      if (commit_valid_i) begin
        for (int i = 0; i < Depth; i++) begin
          if (r_q_valid[i] && (r_q_id[i] == commit_id_i)) begin
            if (commit_kill_i) r_q_kill[i]   <= 1'b1;
            else               r_q_commit[i] <= 1'b1;
          end
        end
      end
      if (w_enq) begin
        r_q_id[r_tail]     <= issue_id_i;
        r_q_op[r_tail]     <= w_dec_op;
        r_q_rs1[r_tail]    <= issue_rs1_i;
        r_q_rs2[r_tail]    <= issue_rs2_i;
        r_q_rd[r_tail]     <= issue_instr_i[11:7];
        r_q_valid[r_tail]  <= 1'b1;
        // A commit/kill arriving alongside its own issue lands on the new entry.
        r_q_commit[r_tail] <= commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
        r_q_kill[r_tail]   <= commit_valid_i &&  commit_kill_i && (commit_id_i == issue_id_i);
        r_tail             <= r_tail + PtrW'(1);
      end
      if (w_pop) begin
        r_q_valid[r_head] <= 1'b0;
        r_head            <= r_head + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_enq) - CntW'(w_pop);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_head_valid) begin
          if (r_q_kill[r_head]) begin
            w_pop = 1'b1;
          end else if (r_q_commit[r_head]) begin
            w_start     = 1'b1;
            w_state_nxt = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (r_cnt == LatW'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (result_ready_i) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ALU on latched operands; all arithmetic wraps at XLen bits
  assign w_prod = r_a * r_b;
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_MUL:  w_alu = w_prod;
      OP_MAC:  w_alu = r_acc + w_prod;
      default: w_alu = '0;
    endcase
  end

  // Datapath: latch head operands, count down latency, capture result and acc
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_res_data <= '0;
      r_res_id   <= '0;
      r_res_rd   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_start) begin
        r_op     <= r_q_op[r_head];
        r_a      <= r_q_rs1[r_head];
        r_b      <= r_q_rs2[r_head];
        r_res_id <= r_q_id[r_head];
        r_res_rd <= r_q_rd[r_head];
        r_cnt    <= r_q_op[r_head][1] ? LatW'(MulLatency) : LatW'(1);
      end else if (r_state == ST_EXEC) begin
        r_cnt <= r_cnt - LatW'(1);
      end
      if (w_finish) begin
        r_res_data <= w_alu;
        if (r_op == OP_MAC) r_acc <= w_alu;
      end
    end
  end

  assign result_valid_o = (r_state == ST_RESP);
  assign result_we_o    = (r_state == ST_RESP);
  assign result_id_o    = r_res_id;
  assign result_rd_o    = r_res_rd;
  assign result_data_o  = r_res_data;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_cvxif_mac_coprocessor.sv
// Directed bench for cvxif_mac_coprocessor with hand-computed expectations.
module tb_cvxif_mac_coprocessor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i;
  logic [63:0] issue_rs1_i, issue_rs2_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i;
  logic [2:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o, result_ready_i;
  logic [2:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [63:0] result_data_o;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  cvxif_mac_coprocessor dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .issue_instr_i     (issue_instr_i),
    .issue_id_i        (issue_id_i),
    .issue_rs1_i       (issue_rs1_i),
    .issue_rs2_i       (issue_rs2_i),
    .issue_rs_valid_i  (issue_rs_valid_i),
    .issue_accept_o    (issue_accept_o),
    .issue_writeback_o (issue_writeback_o),
    .commit_valid_i    (commit_valid_i),
    .commit_id_i       (commit_id_i),
    .commit_kill_i     (commit_kill_i),
    .result_valid_o    (result_valid_o),
    .result_ready_i    (result_ready_i),
    .result_id_o       (result_id_o),
    .result_rd_o       (result_rd_o),
    .result_we_o       (result_we_o),
    .result_data_o     (result_data_o),
    .dbg_state_o       (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd2, 5'd1, f3, rd, 7'b1111011};
  endfunction

  // driver: one issue transfer, returning the decode/ready seen during it
  task automatic issue(input logic [31:0] instr, input logic [2:0] id,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic acc, output logic wb, output logic rdy);
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_id_i    = id;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
    #1;
    acc = issue_accept_o;
    wb  = issue_writeback_o;
    rdy = issue_ready_o;
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    tick();
    commit_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!result_valid_o && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(result_valid_o), 64'd1);
  endtask

  task automatic get_result(input string tag, input logic [2:0] id,
                            input logic [4:0] rd, input logic [63:0] data);
    wait_valid(tag);
    chk({tag, "_id"},   64'(result_id_o), 64'(id));
    chk({tag, "_rd"},   64'(result_rd_o), 64'(rd));
    chk({tag, "_we"},   64'(result_we_o), 64'd1);
    chk({tag, "_data"}, result_data_o,    data);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic no_result(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      if (result_valid_o) seen++;
      tick();
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  logic acc, wb, rdy;
  int   bad;

  initial begin
    rst_ni           = 1'b0;
    issue_valid_i    = 1'b0;
    issue_instr_i    = '0;
    issue_id_i       = '0;
    issue_rs1_i      = '0;
    issue_rs2_i      = '0;
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = 1'b0;
    commit_id_i      = '0;
    commit_kill_i    = 1'b0;
    result_ready_i   = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_we",    64'(result_we_o),    64'd0);
    chk("rst_id",    64'(result_id_o),    64'd0);
    chk("rst_rd",    64'(result_rd_o),    64'd0);
    chk("rst_data",  result_data_o,       64'd0);
    chk("rst_ready", 64'(issue_ready_o),  64'd1);
    chk("rst_state", 64'(dbg_state_o),    64'd0);
    rst_ni = 1'b1;
    issue_instr_i = mk(3'd0, 5'd0);
    #1;
    chk("accept_no_valid", 64'(issue_accept_o), 64'd0);
    issue_rs_valid_i = 2'b01;
    #1;
    chk("ready_rs_invalid", 64'(issue_ready_o), 64'd0);
    issue_rs_valid_i = 2'b11;
    tick();

    // ADD: 5 + 7, result two cycles after commit
    issue(32'h0020807B, 3'd1, 64'd5, 64'd7, acc, wb, rdy);
    chk("add_accept", 64'(acc), 64'd1);
    chk("add_wb",     64'(wb),  64'd1);
    chk("add_ready",  64'(rdy), 64'd1);
    commit(3'd1, 1'b0);
    tick();
    chk("add_lat1", 64'(result_valid_o), 64'd0);
    tick();
    chk("add_lat2", 64'(result_valid_o), 64'd1);
    get_result("add", 3'd1, 5'd0, 64'd12);

    // SUB wrap, committed in the same cycle it is issued
    issue_valid_i  = 1'b1;
    issue_instr_i  = mk(3'd1, 5'd9);
    issue_id_i     = 3'd7;
    issue_rs1_i    = 64'd0;
    issue_rs2_i    = 64'd1;
    commit_valid_i = 1'b1;
    commit_id_i    = 3'd7;
    commit_kill_i  = 1'b0;
    tick();
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    tick();
    chk("sub_lat1", 64'(result_valid_o), 64'd0);
    tick();
    chk("sub_lat2", 64'(result_valid_o), 64'd1);
    get_result("sub", 3'd7, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF);

    // MAC: 3*4 -> 12, then 2*5 -> 22; MAC latency is 1+3 cycles
    issue(mk(3'd3, 5'd5), 3'd2, 64'd3, 64'd4, acc, wb, rdy);
    chk("mac1_accept", 64'(acc), 64'd1);
    commit(3'd2, 1'b0);
    tick();
    tick();
    tick();
    chk("mac_lat3", 64'(result_valid_o), 64'd0);
    tick();
    chk("mac_lat4", 64'(result_valid_o), 64'd1);
    issue(mk(3'd3, 5'd6), 3'd3, 64'd2, 64'd5, acc, wb, rdy);
    commit(3'd3, 1'b0);
    get_result("mac1", 3'd2, 5'd5, 64'd12);
    get_result("mac2", 3'd3, 5'd6, 64'd22);

    // reset while a committed MAC is executing: discarded, acc cleared
    issue(mk(3'd3, 5'd6), 3'd4, 64'd10, 64'd10, acc, wb, rdy);
    commit(3'd4, 1'b0);
    tick();
    chk("mid_state_exec", 64'(dbg_state_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    chk("mid_rst_state", 64'(dbg_state_o),   64'd0);
    chk("mid_rst_ready", 64'(issue_ready_o), 64'd1);
    chk("mid_rst_data",  result_data_o,      64'd0);
    no_result("mid_rst_no_result", 8);
    issue(mk(3'd3, 5'd7), 3'd5, 64'd1, 64'd1, acc, wb, rdy);
    commit(3'd5, 1'b0);
    get_result("mac_after_rst", 3'd5, 5'd7, 64'd1);

    // rejects: wrong opcode and funct3=5
    issue(32'h00208033, 3'd5, 64'd1, 64'd2, acc, wb, rdy);
    chk("rej_op_accept", 64'(acc), 64'd0);
    chk("rej_op_wb",     64'(wb),  64'd0);
    chk("rej_op_ready",  64'(rdy), 64'd1);
    issue(mk(3'd5, 5'd3), 3'd6, 64'd1, 64'd2, acc, wb, rdy);
    chk("rej_f3_accept", 64'(acc), 64'd0);
    chk("rej_f3_wb",     64'(wb),  64'd0);
    commit(3'd5, 1'b0);
    commit(3'd6, 1'b0);
    no_result("rej_no_result", 10);

    // fill queue with ids 0..3, fifth is stalled
    issue(mk(3'd0, 5'd1), 3'd0, 64'd1,   64'd1,   acc, wb, rdy);
    issue(mk(3'd1, 5'd2), 3'd1, 64'd9,   64'd3,   acc, wb, rdy);
    issue(mk(3'd2, 5'd3), 3'd2, 64'd6,   64'd7,   acc, wb, rdy);
    issue(mk(3'd0, 5'd4), 3'd3, 64'd100, 64'd200, acc, wb, rdy);
    chk("fill4_ready", 64'(rdy), 64'd1);
    issue_valid_i = 1'b1;
    issue_instr_i = mk(3'd0, 5'd8);
    issue_id_i    = 3'd4;
    #1;
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    tick();
    issue_valid_i = 1'b0;
    chk("full_idle", 64'(dbg_state_o), 64'd0);
    commit(3'd1, 1'b1);
    commit(3'd0, 1'b0);
    commit(3'd2, 1'b0);
    commit(3'd3, 1'b0);
    get_result("q0", 3'd0, 5'd1, 64'd2);
    get_result("q2", 3'd2, 5'd3, 64'd42);
    get_result("q3", 3'd3, 5'd4, 64'd300);
    no_result("q_no_extra", 10);
    chk("q_drained_ready", 64'(issue_ready_o), 64'd1);

    // backpressure: ready low for 10 cycles in RESP
    issue(mk(3'd0, 5'd10), 3'd6, 64'h1234, 64'd1, acc, wb, rdy);
    commit(3'd6, 1'b0);
    wait_valid("bp");
    bad = 0;
    repeat (10) begin
      tick();
      if (!result_valid_o || result_data_o !== 64'h1235 ||
          result_id_o !== 3'd6 || result_rd_o !== 5'd10) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk("bp_pop_valid", 64'(result_valid_o), 64'd0);
    chk("bp_pop_state", 64'(dbg_state_o),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
